// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: one word read per instruction, {pc, instr} to decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_next_address,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_flush_address,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_rvalid,
    input  logic [WIDTH-1:0] i_imem_rdata,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_instr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_fetch_count,
    output logic [31:0]      o_flush_count
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;
    logic             valid_q;
    logic             handshake;

    assign handshake   = (state_q == S_HOLD) && i_ready;
    assign o_imem_req  = (state_q == S_ISSUE);
    assign o_imem_addr = {2'b00, pc_q[WIDTH-1:2]};
    assign o_pc        = pc_q;
    assign o_instr     = instr_q;
    assign o_valid     = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (i_flush) begin
            pc_q    <= i_flush_address;
            valid_q <= 1'b0;
            // A response landing with the flush drains the only outstanding read,
            // so there is nothing left to drop and fetching can restart.
            case (state_q)
                S_ISSUE: state_q <= S_DROP;
                S_WAIT:  state_q <= i_imem_rvalid ? S_ISSUE : S_DROP;
                S_HOLD:  state_q <= S_ISSUE;
                S_DROP:  state_q <= i_imem_rvalid ? S_ISSUE : S_DROP;
                default: state_q <= S_ISSUE;
            endcase
        end else begin
            case (state_q)
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        instr_q <= i_imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        pc_q    <= i_next_address;
                        valid_q <= 1'b0;
                        state_q <= S_ISSUE;
                    end
                end
                S_DROP: begin
                    if (i_imem_rvalid) begin
                        state_q <= S_ISSUE;
                    end
                end
                default: state_q <= S_ISSUE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Handshakes count even when a flush lands in the same cycle.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (handshake) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (i_flush)   flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_fetch_count = fetch_cnt_q;
    assign o_flush_count = flush_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
    assign o_fetch_count    = 32'd0;
    assign o_flush_count    = 32'd0;
`endif

endmodule
